// File: rtl/branch_resolve_ctrl.sv
// ID-stage conditional branch resolution: operand hazard stalls, signed/unsigned-equality
// compare, one-cycle redirect with IF/ID flush. Optional statistics counters under BRANCH_STAT_EN.
module branch_resolve_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              branch_i,
    input  logic [1:0]        bop_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] target_i,
    input  logic              ex_regwrite_i,
    input  logic              mem_regwrite_i,
    input  logic [4:0]        ex_rd_i,
    input  logic [4:0]        mem_rd_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] pc_target_o
`ifdef BRANCH_STAT_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt_o,
    output logic [CNT_W-1:0]  nottaken_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   hazard;
    logic   cond;
    logic   capture;

    // Register 0 is hardwired, so a pending write to it never blocks a branch.
    always_comb begin
        hazard = 1'b0;
        if (ex_regwrite_i && (ex_rd_i != 5'd0) &&
            ((ex_rd_i == rs_addr_i) || (ex_rd_i == rt_addr_i)))
            hazard = 1'b1;
        if (mem_regwrite_i && (mem_rd_i != 5'd0) &&
            ((mem_rd_i == rs_addr_i) || (mem_rd_i == rt_addr_i)))
            hazard = 1'b1;
    end

    always_comb begin
        cond = 1'b0;
        case (bop_i)
            2'b00:   cond = (rs_data_i != rt_data_i);
            2'b01:   cond = (rs_data_i == rt_data_i);
            2'b10:   cond = ($signed(rs_data_i) >  $signed(rt_data_i));
            default: cond = ($signed(rs_data_i) >= $signed(rt_data_i));
        endcase
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE, STALL: begin
                if (!branch_i) begin
                    state_d = IDLE;
                end else if (hazard) begin
                    state_d = STALL;
                end else if (cond) begin
                    state_d = REDIRECT;
                    capture = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_target_o <= '0;
        end else begin
            state_q <= state_d;
            if (capture)
                pc_target_o <= target_i;
        end
    end

    // Reset masks the control outputs immediately, not just from the next edge.
    assign stall_o  = !rst_i && branch_i && hazard && (state_q != REDIRECT);
    assign flush_o  = !rst_i && (state_q == REDIRECT);
    assign pc_src_o = !rst_i && (state_q == REDIRECT);

`ifdef BRANCH_STAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic nottaken;
    assign nottaken = branch_i && !hazard && !cond && (state_q != REDIRECT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taken_cnt_o    <= '0;
            nottaken_cnt_o <= '0;
            stall_cnt_o    <= '0;
        end else begin
            if (capture && (taken_cnt_o != CNT_MAX))
                taken_cnt_o <= taken_cnt_o + CNT_W'(1);
            if (nottaken && (nottaken_cnt_o != CNT_MAX))
                nottaken_cnt_o <= nottaken_cnt_o + CNT_W'(1);
            if (stall_o && (stall_cnt_o != CNT_MAX))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus random traffic against
// a cycle-level reference model of branch outcomes.
module tb_branch_resolve_ctrl;
    localparam int DW = 32;
`ifdef BRANCH_STAT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          branch_i = 1'b0;
    logic [1:0]    bop_i = 2'b00;
    logic [4:0]    rs_addr_i = '0, rt_addr_i = '0, ex_rd_i = '0, mem_rd_i = '0;
    logic [DW-1:0] rs_data_i = '0, rt_data_i = '0, target_i = '0;
    logic          ex_regwrite_i = 1'b0, mem_regwrite_i = 1'b0;
    logic          stall_o, flush_o, pc_src_o;
    logic [DW-1:0] pc_target_o;
`ifdef BRANCH_STAT_EN
    logic [CW-1:0] taken_cnt_o, nottaken_cnt_o, stall_cnt_o;
`endif

    branch_resolve_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .branch_i(branch_i), .bop_i(bop_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .target_i(target_i),
        .ex_regwrite_i(ex_regwrite_i), .mem_regwrite_i(mem_regwrite_i),
        .ex_rd_i(ex_rd_i), .mem_rd_i(mem_rd_i),
        .stall_o(stall_o), .flush_o(flush_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o)
`ifdef BRANCH_STAT_EN
        , .taken_cnt_o(taken_cnt_o), .nottaken_cnt_o(nottaken_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: is the current cycle a redirect, which target is held, event tallies.
    bit            m_redir = 1'b0;
    logic [DW-1:0] m_target = '0;
    int            m_taken = 0, m_nt = 0, m_stall = 0;
    logic [DW+2:0] exp_vec;
    logic [DW+2:0] act_vec;
    assign act_vec = {stall_o, flush_o, pc_src_o, pc_target_o};

    function automatic bit ref_hazard();
        bit ex_hit, mem_hit;
        ex_hit  = ex_regwrite_i && ex_rd_i != 0 && (ex_rd_i == rs_addr_i || ex_rd_i == rt_addr_i);
        mem_hit = mem_regwrite_i && mem_rd_i != 0 && (mem_rd_i == rs_addr_i || mem_rd_i == rt_addr_i);
        return ex_hit || mem_hit;
    endfunction

    function automatic bit ref_cond();
        int signed a, b;
        a = $signed(rs_data_i);
        b = $signed(rt_data_i);
        case (bop_i)
            2'b00:   return a != b;
            2'b01:   return a == b;
            2'b10:   return a > b;
            default: return a >= b;
        endcase
    endfunction

    function automatic int sat(input int v);
        int mx;
        mx = (1 << CW) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive(input bit br, input logic [1:0] op, input logic [4:0] rsa, input logic [4:0] rta,
                         input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [DW-1:0] tgt);
        branch_i = br; bop_i = op; rs_addr_i = rsa; rt_addr_i = rta;
        rs_data_i = rsd; rt_data_i = rtd; target_i = tgt;
    endtask

    task automatic hz(input bit exw, input logic [4:0] exrd, input bit mw, input logic [4:0] mrd);
        ex_regwrite_i = exw; ex_rd_i = exrd; mem_regwrite_i = mw; mem_rd_i = mrd;
    endtask

    task automatic quiet();
        drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, '0);
        hz(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // Wait to mid-cycle and form the expected output vector for the current inputs.
    task automatic sample();
        @(negedge clk);
        exp_vec = {!rst_i && !m_redir && branch_i && ref_hazard(),
                   !rst_i && m_redir, !rst_i && m_redir, m_target};
    endtask

    // Apply the clock edge to the model and the DUT.
    task automatic advance();
        if (rst_i) begin
            m_redir = 1'b0; m_target = '0; m_taken = 0; m_nt = 0; m_stall = 0;
        end else if (m_redir) begin
            m_redir = 1'b0;
        end else if (branch_i) begin
            if (ref_hazard()) m_stall++;
            else if (ref_cond()) begin m_redir = 1'b1; m_target = target_i; m_taken++; end
            else m_nt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b1, 2'b01, 5'd3, 5'd3, 32'd1, 32'd1, 32'h44);
        hz(1'b1, 5'd3, 1'b0, 5'd0);
        advance();
        sample();
        checks++;
        if (act_vec !== '0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", act_vec, {(DW+3){1'b0}});
        end
        advance();
        rst_i = 1'b0;
        quiet();
        sample();
        checks++;
        if (act_vec !== exp_vec) begin
            errors++; $display("FAIL reset_release: got %h expected %h", act_vec, exp_vec);
        end
        advance();
    endtask

    task automatic test_beq_taken();
        drive(1'b1, 2'b01, 5'd1, 5'd2, 32'd5, 32'd5, 32'h40);
        for (int s = 0; s < 3; s++) begin
            if (s > 0) quiet();
            sample();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL beq_taken_s%0d: got %h expected %h", s, act_vec, exp_vec);
            end
            if (s == 1) begin
                checks++;
                if ({flush_o, pc_src_o, pc_target_o} !== {2'b11, 32'h40}) begin
                    errors++; $display("FAIL beq_redirect: got %b%b %h expected 11 00000040", flush_o, pc_src_o, pc_target_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_signed_compare();
        drive(1'b1, 2'b10, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'h80);
        sample();
        advance();
        quiet();
        sample();
        checks++;
        if (flush_o !== 1'b0 || act_vec !== exp_vec) begin
            errors++; $display("FAIL bgt_signed: got %h expected %h", act_vec, exp_vec);
        end
        drive(1'b1, 2'b11, 5'd1, 5'd2, 32'd7, 32'd7, 32'hC0);
        advance();
        quiet();
        sample();
        checks++;
        if ({flush_o, pc_target_o} !== {1'b1, 32'hC0} || act_vec !== exp_vec) begin
            errors++; $display("FAIL bge_equal: got %h expected %h", act_vec, exp_vec);
        end
        advance();
    endtask

    task automatic test_hazard();
        int stalls;
        stalls = 0;
        for (int s = 0; s < 4; s++) begin
            if (s < 3) drive(1'b1, 2'b01, 5'd3, 5'd4, 32'd9, 32'd9, 32'h1234);
            else quiet();
            case (s)
                0: hz(1'b1, 5'd3, 1'b0, 5'd0);
                1: hz(1'b0, 5'd0, 1'b1, 5'd3);
                default: hz(1'b0, 5'd0, 1'b0, 5'd0);
            endcase
            sample();
            if (stall_o === 1'b1) stalls++;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL hazard_s%0d: got %h expected %h", s, act_vec, exp_vec);
            end
            if (s == 3) begin
                checks++;
                if (stalls != 2 || flush_o !== 1'b1 || pc_target_o !== 32'h1234) begin
                    errors++; $display("FAIL hazard_decision: got stalls=%0d flush=%b tgt=%h expected stalls=2 flush=1 tgt=00001234",
                                       stalls, flush_o, pc_target_o);
                end
            end
            advance();
        end
        drive(1'b1, 2'b00, 5'd0, 5'd5, 32'd1, 32'd1, 32'h50);
        hz(1'b1, 5'd0, 1'b1, 5'd0);
        sample();
        checks++;
        if (stall_o !== 1'b0 || act_vec !== exp_vec) begin
            errors++; $display("FAIL r0_no_hazard: got %h expected %h", act_vec, exp_vec);
        end
        advance();
        quiet();
        sample();
        advance();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] want;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: drive(1'b1, 2'b01, 5'd1, 5'd2, 32'd3, 32'd3, 32'h100);
                1: drive(1'b1, 2'b01, 5'd1, 5'd2, 32'd3, 32'd3, 32'h200);
                2: drive(1'b1, 2'b00, 5'd1, 5'd2, 32'd3, 32'd4, 32'h300);
                default: quiet();
            endcase
            sample();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL b2b_s%0d: got %h expected %h", s, act_vec, exp_vec);
            end
            if (s == 1 || s == 3) begin
                want = (s == 1) ? 32'h100 : 32'h300;
                checks++;
                if (flush_o !== 1'b1 || pc_target_o !== want) begin
                    errors++; $display("FAIL b2b_target_s%0d: got flush=%b tgt=%h expected flush=1 tgt=%h", s, flush_o, pc_target_o, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                drive(1'b1, 2'b01, 5'd3, 5'd4, 32'd2, 32'd2, 32'h600);
                hz(1'b1, 5'd3, 1'b0, 5'd0);
            end else begin
                drive(1'b1, 2'b01, 5'd3, 5'd4, 32'd2, 32'd2, 32'h700);
                hz(1'b0, 5'd0, 1'b0, 5'd0);
            end
            sample();
            advance();
            rst_i = 1'b1;
            drive(1'b1, 2'b01, 5'd3, 5'd4, 32'd2, 32'd2, 32'h800);
            hz(1'b1, 5'd4, 1'b0, 5'd0);
            sample();
            checks++;
            if ({stall_o, flush_o, pc_src_o} !== 3'b000) begin
                errors++; $display("FAIL reset_mid_hold_%0d: got %b%b%b expected 000", r, stall_o, flush_o, pc_src_o);
            end
            advance();
            rst_i = 1'b0;
            quiet();
            for (int k = 0; k < 2; k++) begin
                sample();
                checks++;
                if (act_vec !== '0 || act_vec !== exp_vec) begin
                    errors++; $display("FAIL reset_mid_after_%0d_%0d: got %h expected %h", r, k, act_vec, exp_vec);
                end
                advance();
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_i = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  DW'($urandom_range(0, 3)) - DW'(1), DW'($urandom_range(0, 3)) - DW'(1), DW'($urandom));
            hz($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
            sample();
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL random_c%0d: got %h expected %h", c, act_vec, exp_vec);
            end
`ifdef BRANCH_STAT_EN
            checks++;
            if (int'(taken_cnt_o) != sat(m_taken) || int'(nottaken_cnt_o) != sat(m_nt) || int'(stall_cnt_o) != sat(m_stall)) begin
                errors++; $display("FAIL random_cnt_c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                                   taken_cnt_o, nottaken_cnt_o, stall_cnt_o, sat(m_taken), sat(m_nt), sat(m_stall));
            end
`endif
            advance();
        end
        rst_i = 1'b0;
        quiet();
    endtask

`ifdef BRANCH_STAT_EN
    task automatic test_stats();
        rst_i = 1'b1;
        quiet();
        advance();
        rst_i = 1'b0;
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, 2'b01, 5'd1, 5'd2, 32'd6, 32'd6, DW'(b * 16));
            sample();
            advance();
            quiet();
            sample();
            advance();
        end
        sample();
        checks++;
        if (taken_cnt_o !== 2'd3 || int'(taken_cnt_o) != sat(m_taken)) begin
            errors++; $display("FAIL taken_saturate: got %0d expected 3", taken_cnt_o);
        end
        advance();
    endtask
`endif

    initial begin
        test_reset();
        test_beq_taken();
        test_signed_compare();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef BRANCH_STAT_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter: DATA_W, default 32, width of register operands and branch target.
REQ-002 Parameter: CNT_W, default 16, width of statistics counters (used only with BRANCH_STAT_EN).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports SHALL be:
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 branch_i  in  1  ID-stage instruction is a conditional branch.
REQ-007 bop_i  in  2  {bgt,beq}: 00 bne, 01 beq, 10 bgt, 11 bge.
REQ-008 rs_addr_i, rt_addr_i  in  5 each  ID-stage source register numbers.
REQ-009 rs_data_i, rt_data_i  in  DATA_W each  register-file read data.
REQ-010 target_i  in  DATA_W  computed branch target (PC+4+offset<<2).
REQ-011 ex_regwrite_i, mem_regwrite_i  in  1 each  EX/MEM-stage instruction writes a register.
REQ-012 ex_rd_i, mem_rd_i  in  5 each  EX/MEM-stage destination register.
REQ-013 stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-014 flush_o  out  1  squash IF/ID contents.
REQ-015 pc_src_o  out  1  select pc_target_o as next PC.
REQ-016 pc_target_o  out  DATA_W  redirect address.

Function
REQ-017 hazard SHALL be 1 when (ex_regwrite_i & ex_rd_i!=0 & ex_rd_i in {rs_addr_i,rt_addr_i}) or the same condition on mem_*; register 0 never hazards.
REQ-018 FSM states SHALL be IDLE, STALL, REDIRECT; reset state IDLE.
REQ-019 cond SHALL be: bne rs!=rt; beq rs==rt; bgt rs>rt; bge rs>=rt; bgt/bge compare signed two's complement.
REQ-020 stall_o SHALL be combinational: 1 iff state in {IDLE,STALL} & branch_i & hazard.
REQ-021 IDLE: branch_i & hazard -> STALL; branch_i & !hazard & cond -> REDIRECT, target_i captured; branch_i & !hazard & !cond -> stay IDLE; !branch_i -> stay IDLE.
REQ-022 STALL: !branch_i -> IDLE, no decision; hazard -> stay STALL; !hazard -> evaluate cond same cycle, cond -> REDIRECT (capture target_i), else IDLE.
REQ-023 REDIRECT SHALL last exactly one cycle, then IDLE; in it flush_o=1, pc_src_o=1, pc_target_o=captured target; branch_i ignored.
REQ-024 flush_o and pc_src_o SHALL be 0 outside REDIRECT; pc_target_o SHALL hold last captured value.
REQ-025 Decision latency SHALL be 1 cycle after the non-hazard evaluation cycle; stall count per branch bounded by hazard duration (max 2 with standard 5-stage pipe).
REQ-026 A branch in ID the cycle after REDIRECT SHALL be evaluated normally (back-to-back branches allowed).

Reset
REQ-027 rst_i=1 at a rising edge SHALL force state IDLE, pc_target_o=0, all counters 0.
REQ-028 While rst_i=1, stall_o, flush_o, pc_src_o SHALL be 0 regardless of inputs.
REQ-029 Reset in STALL or REDIRECT SHALL abandon the branch with no redirect after release.

Configuration
REQ-030 Macro BRANCH_STAT_EN defined: ports taken_cnt_o, nottaken_cnt_o, stall_cnt_o (out, CNT_W each) SHALL exist.
REQ-031 taken_cnt_o +1 per REDIRECT entry; nottaken_cnt_o +1 per not-taken decision; stall_cnt_o +1 per cycle stall_o=1; all saturate at 2^CNT_W-1.
REQ-032 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 beq, rs=rt=5, no hazard, target_i=0x40 -> next cycle flush_o=1, pc_src_o=1, pc_target_o=0x40 for one cycle.
REQ-034 bgt, rs=0xFFFFFFFF, rt=1 -> not taken (signed), no flush; bge rs=rt=7 -> taken.
REQ-035 beq rs_addr=3, ex_regwrite=1, ex_rd=3 then mem_rd=3 -> stall_o=1 two cycles, then decision; ex_rd=0 -> no stall.
REQ-036 Taken branch followed immediately by second taken branch -> two REDIRECT cycles separated by one evaluation cycle, targets correct.
REQ-037 rst_i asserted during STALL and during REDIRECT -> next cycle all outputs 0, state IDLE, no late redirect.
REQ-038 BRANCH_STAT_EN, CNT_W=2: 5 taken branches -> taken_cnt_o=3 (saturated); build without macro compiles without counter ports.
